cnt_timer_core: RTL and testbench
=================================

Name: cnt_timer_core

Overview:
- Counter/timer engine that sits directly downstream of the peripheral register block.
- Consumes the decoded CTRL0, CNT_MODE0, CNT_MODE1 fields and the CMD pulses.
- Produces the live count value and the captured value/running status, which feed the ACT_CNT and CAPTURED read registers.
- Drives the timer output pin and a match pulse.

Parameters:
- CNT_W, 10, counter/target/capture width. Only 10 is supported.
- SYNC_STAGES, 2, synchroniser depth on external trigger/capture inputs.

Ports:
- clk_i  in  1  system clock; all flops on its rising edge
- rstn_i  in  1  asynchronous active-low reset
- ctrl0_i  in  2  [0] enable; [1] start mode (0 = run on enable, 1 = wait for trigger)
- cnt_timer_mode_in_i  in  4  counting mode (see Behaviour)
- cnt_timer_trigger_sel_i  in  2  trigger source: 00 sw, 01 ext_trig_i[0], 10 ext_trig_i[1], 11 either ext
- cnt_timer_out_i  in  1  timer_out_o toggle enable
- cnt_timer_capt_sel_i  in  2  capture source: 00 on trigger, 01 ext_capt_i rising edge, 10 on target match, 11 off
- cnt_timer1_target_i  in  10  target/reload value
- cmd_clear_i  in  1  single-cycle clear pulse
- cmd_sw_trigger_i  in  1  single-cycle software trigger pulse
- ext_trig_i  in  2  asynchronous external trigger lines
- ext_capt_i  in  1  asynchronous external capture line
- act_cnt_val_o  out  10  current counter value (registered)
- captured_status_value_o  out  10  last captured counter value
- captured_status_tm_running_o  out  1  1 while the FSM is in RUN
- timer_out_o  out  1  timer output pin
- match_pulse_o  out  1  one-cycle pulse, registered, on target match

Behaviour:
- Reset: every output is 0; FSM = IDLE; synchroniser flops are 0.
- External inputs:
  - Each passes SYNC_STAGES flops plus one history flop; edge = sync_out & ~history.
  - An ext input that rises before clock edge k takes effect at edge k+3.
  - cmd_* inputs are already synchronous and take effect on the next edge.
- FSM states: IDLE, ARMED, RUN, DONE.
  - IDLE -> RUN when ctrl0_i[0]=1 and ctrl0_i[1]=0.
  - IDLE -> ARMED when ctrl0_i[0]=1 and ctrl0_i[1]=1.
  - ARMED -> RUN on the selected trigger event.
  - RUN -> DONE on match in one-shot mode only.
  - DONE holds until cmd_clear_i or enable drop.
  - Any state -> IDLE whenever ctrl0_i[0]=0. The counter holds its value; it does not clear.
- Modes (cnt_timer_mode_in_i), applied in RUN only, one step per clock:
  - 0 free-run up: 0..1023, wraps 1023 -> 0; match when count == target.
  - 1 one-shot up: counts 0..target, stops at target, match, then -> DONE.
  - 2 periodic up: counts 0..target, reloads 0 on the cycle after target; match at target.
  - 3 periodic down: loads target on entry to RUN, counts to 0, reloads target; match at 0.
  - 4..15 reserved: counter holds; no match.
- Target = 0:
  - Mode 2 stays at 0 and matches every cycle.
  - Mode 1 matches on the first RUN cycle and enters DONE.
  - Mode 3 behaves like mode 2.
- Trigger while already in RUN: restarts the count (0, or target in mode 3) without leaving RUN.
- Capture: captured_status_value_o <= act_cnt_val_o as it was before that cycle's update. Capture is valid in any state except IDLE.
- timer_out_o toggles on each match when cnt_timer_out_i=1; it is held otherwise.
- cmd_clear_i has priority over count, trigger, capture and match. It causes:
  - counter <= 0 (target in mode 3)
  - captured_status_value_o <= 0
  - timer_out_o <= 0
  - FSM re-enters ARMED or RUN per ctrl0_i[1], if enabled.
- Simultaneous trigger and capture with capt_sel=00: the capture takes the pre-restart value.
- Mode or target change during RUN takes effect on the next clock. In an up mode, a count already above a lowered target runs on to wrap 1023 -> 0.
- Reset asserted mid-count: all state clears immediately (asynchronous); no pulse is emitted on release.

Test Plan:
- Reset mid-run in mode 2 -> all outputs 0 immediately; after release with ctrl0=01 counting resumes from 0.
- ctrl0=01, mode 2, target 5 -> act_cnt 0,1,2,3,4,5,0,... with match_pulse_o at every 5. With cnt_timer_out_i=1, timer_out_o toggles every 6 cycles.
- ctrl0=11, mode 1, target 3, trigger_sel 01, ext_trig_i[0] rises before edge k -> RUN at edge k+3. Count 0..3, match once, DONE; tm_running 1 -> 0; count holds 3.
- Mode 3, target 4, capt_sel 01, ext_capt_i pulse while count=2 sampled -> captured value 2, three edges later per synchroniser timing. Count sequence is 4,3,2,1,0,4.
- Mode 0 from 1020 -> 1021,1022,1023,0 wrap. cmd_clear_i coinciding with sw trigger and match -> count 0, captured 0, no match_pulse_o.
- Target 0, mode 2 -> count stays 0, match_pulse_o high every cycle. Dropping ctrl0[0] -> IDLE, tm_running 0, count held.

Source files
------------

// File: rtl/cnt_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_timer_if
// Description : Register-block <-> counter/timer engine bundle. Carries the
//               decoded control fields, command pulses, raw external lines
//               and the live/captured status returned to the read registers.
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_timer_if #(
    parameter int CNT_W = 10
);
    logic [1:0]       ctrl0_i;
    logic [3:0]       cnt_timer_mode_in_i;
    logic [1:0]       cnt_timer_trigger_sel_i;
    logic             cnt_timer_out_i;
    logic [1:0]       cnt_timer_capt_sel_i;
    logic [CNT_W-1:0] cnt_timer1_target_i;
    logic             cmd_clear_i;
    logic             cmd_sw_trigger_i;
    logic [1:0]       ext_trig_i;
    logic             ext_capt_i;
    logic [CNT_W-1:0] act_cnt_val_o;
    logic [CNT_W-1:0] captured_status_value_o;
    logic             captured_status_tm_running_o;
    logic             timer_out_o;
    logic             match_pulse_o;

    // Register block / pin side: drives configuration, observes status
    modport master (
        output ctrl0_i, cnt_timer_mode_in_i, cnt_timer_trigger_sel_i,
               cnt_timer_out_i, cnt_timer_capt_sel_i, cnt_timer1_target_i,
               cmd_clear_i, cmd_sw_trigger_i, ext_trig_i, ext_capt_i,
        input  act_cnt_val_o, captured_status_value_o,
               captured_status_tm_running_o, timer_out_o, match_pulse_o
    );

    // Counter engine side
    modport slave (
        input  ctrl0_i, cnt_timer_mode_in_i, cnt_timer_trigger_sel_i,
               cnt_timer_out_i, cnt_timer_capt_sel_i, cnt_timer1_target_i,
               cmd_clear_i, cmd_sw_trigger_i, ext_trig_i, ext_capt_i,
        output act_cnt_val_o, captured_status_value_o,
               captured_status_tm_running_o, timer_out_o, match_pulse_o
    );
endinterface
`default_nettype wire

// File: rtl/cnt_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_timer_core
// Description : Counter/timer engine. IDLE/ARMED/RUN/DONE sequencer with
//               free-run, one-shot, periodic-up and periodic-down modes,
//               synchronised external trigger/capture, value capture, match
//               pulse and toggling timer output.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_timer_core #(
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    cnt_timer_if.slave bus
);

    localparam logic [3:0] c_MODE_FREE     = 4'd0;
    localparam logic [3:0] c_MODE_ONESHOT  = 4'd1;
    localparam logic [3:0] c_MODE_PERIODIC = 4'd2;
    localparam logic [3:0] c_MODE_DOWN     = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // bit 0/1: ext_trig_i[0]/[1], bit 2: ext_capt_i
    logic [2:0]       r_sync [SYNC_STAGES];
    logic [2:0]       r_hist;
    logic [2:0]       r_edge;
    logic [2:0]       w_ext_raw;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_capt;
    logic [CNT_W-1:0] w_capt_nxt;
    logic             r_tout;
    logic             w_tout_nxt;
    logic             r_match;
    logic             w_match;

    logic             w_en;
    logic             w_wait;
    logic             w_trig_evt;
    logic             w_capt_evt;
    logic [CNT_W-1:0] w_start_val;
    logic             w_at_tgt;
    logic             w_at_zero;

    assign w_ext_raw   = {bus.ext_capt_i, bus.ext_trig_i};
    assign w_en        = bus.ctrl0_i[0];
    assign w_wait      = bus.ctrl0_i[1];
    // Down-counting restarts from the target, every up mode from zero
    assign w_start_val = (bus.cnt_timer_mode_in_i == c_MODE_DOWN) ? bus.cnt_timer1_target_i : '0;
    assign w_at_tgt    = (r_cnt == bus.cnt_timer1_target_i);
    assign w_at_zero   = (r_cnt == '0);

    // Synchronise external lines, then register a rising-edge pulse so an
    // input rising before edge k acts on edge k+3
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_hist <= '0;
            r_edge <= '0;
        end else begin
            r_sync[0] <= w_ext_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
            r_edge <= r_sync[SYNC_STAGES-1] & ~r_hist;
        end
    end

    // Select the trigger source
    always_comb begin
        w_trig_evt = 1'b0;
        case (bus.cnt_timer_trigger_sel_i)
            2'b00:   w_trig_evt = bus.cmd_sw_trigger_i;
            2'b01:   w_trig_evt = r_edge[0];
            2'b10:   w_trig_evt = r_edge[1];
            default: w_trig_evt = r_edge[0] | r_edge[1];
        endcase
    end

    // Sequencer and counter next-value; clear beats everything, a trigger in
    // RUN restarts the count and suppresses that cycle's match
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_match     = 1'b0;
        if (bus.cmd_clear_i) begin
            w_cnt_nxt = w_start_val;
            if (!w_en) begin
                w_state_nxt = S_IDLE;
            end else if (w_wait) begin
                w_state_nxt = S_ARMED;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else if (!w_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wait) begin
                        w_state_nxt = S_ARMED;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_start_val;
                    end
                end
                S_ARMED: begin
                    if (w_trig_evt) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = w_start_val;
                    end
                end
                S_RUN: begin
                    if (w_trig_evt) begin
                        w_cnt_nxt = w_start_val;
                    end else begin
                        case (bus.cnt_timer_mode_in_i)
                            c_MODE_FREE: begin
                                w_cnt_nxt = r_cnt + 1'b1;
                                w_match   = w_at_tgt;
                            end
                            c_MODE_ONESHOT: begin
                                if (w_at_tgt) begin
                                    w_match     = 1'b1;
                                    w_state_nxt = S_DONE;
                                end else begin
                                    w_cnt_nxt = r_cnt + 1'b1;
                                end
                            end
                            c_MODE_PERIODIC: begin
                                if (w_at_tgt) begin
                                    w_match   = 1'b1;
                                    w_cnt_nxt = '0;
                                end else begin
                                    w_cnt_nxt = r_cnt + 1'b1;
                                end
                            end
                            c_MODE_DOWN: begin
                                if (w_at_zero) begin
                                    w_match   = 1'b1;
                                    w_cnt_nxt = bus.cnt_timer1_target_i;
                                end else begin
                                    w_cnt_nxt = r_cnt - 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture the pre-update count and toggle the output pin on match
    always_comb begin
        w_capt_evt = 1'b0;
        case (bus.cnt_timer_capt_sel_i)
            2'b00:   w_capt_evt = w_trig_evt;
            2'b01:   w_capt_evt = r_edge[2];
            2'b10:   w_capt_evt = w_match;
            default: w_capt_evt = 1'b0;
        endcase
        w_capt_nxt = r_capt;
        w_tout_nxt = r_tout;
        if (bus.cmd_clear_i) begin
            w_capt_nxt = '0;
            w_tout_nxt = 1'b0;
        end else begin
            if (w_capt_evt && (r_state != S_IDLE)) begin
                w_capt_nxt = r_cnt;
            end
            if (w_match && bus.cnt_timer_out_i) begin
                w_tout_nxt = ~r_tout;
            end
        end
    end

    // State, counter and all registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_capt    <= '0;
            r_tout    <= 1'b0;
            r_match   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_cnt     <= w_cnt_nxt;
            r_capt    <= w_capt_nxt;
            r_tout    <= w_tout_nxt;
            r_match   <= w_match;
        end
    end

    assign bus.act_cnt_val_o                = r_cnt;
    assign bus.captured_status_value_o      = r_capt;
    assign bus.captured_status_tm_running_o = r_running;
    assign bus.timer_out_o                  = r_tout;
    assign bus.match_pulse_o                = r_match;

endmodule
`default_nettype wire

// File: tb/tb_cnt_timer_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_timer_core
// Description : Self-checking bench for cnt_timer_core: directed scenarios
//               plus randomized traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_timer_core;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    cnt_timer_if bus ();

    cnt_timer_core #(.CNT_W(10), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
    int       m_st, m_cnt, m_capt, m_cyc;
    bit       m_tout, m_match, m_run;
    bit [2:0] m_raw_prev;
    bit [2:0] m_pend [8];

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_capt = 0; m_cyc = 0;
        m_tout = 0; m_match = 0; m_run = 0; m_raw_prev = 3'b000;
        for (int i = 0; i < 8; i++) m_pend[i] = 3'b000;
    endtask

    // One rising clock edge of the behaviour, using the inputs as sampled there
    task automatic model_edge();
        bit [2:0] ev, raw;
        bit trg, cap, match, en, wt;
        int mode, tgt, start, pre;
        // an external rise seen at edge k acts at edge k+3
        ev = m_pend[m_cyc % 8];
        m_pend[m_cyc % 8] = 3'b000;
        raw = {bus.ext_capt_i, bus.ext_trig_i};
        m_pend[(m_cyc + 3) % 8] |= raw & ~m_raw_prev;
        m_raw_prev = raw;
        m_cyc++;
        en   = bus.ctrl0_i[0];
        wt   = bus.ctrl0_i[1];
        mode = int'(bus.cnt_timer_mode_in_i);
        tgt  = int'(bus.cnt_timer1_target_i);
        case (bus.cnt_timer_trigger_sel_i)
            2'd0:    trg = bus.cmd_sw_trigger_i;
            2'd1:    trg = ev[0];
            2'd2:    trg = ev[1];
            default: trg = ev[0] | ev[1];
        endcase
        start = (mode == 3) ? tgt : 0;
        pre   = m_cnt;
        match = 0;
        if (bus.cmd_clear_i) begin
            m_cnt = start; m_capt = 0; m_tout = 0;
            m_st  = !en ? M_IDLE : (wt ? M_ARMED : M_RUN);
        end else begin
            if (en && m_st == M_RUN && !trg && mode <= 3)
                match = (mode == 3) ? (pre == 0) : (pre == tgt);
            case (bus.cnt_timer_capt_sel_i)
                2'd0:    cap = trg;
                2'd1:    cap = ev[2];
                2'd2:    cap = match;
                default: cap = 0;
            endcase
            cap = cap && (m_st != M_IDLE);
            if (!en) m_st = M_IDLE;
            else if (m_st == M_IDLE) begin
                if (wt) m_st = M_ARMED;
                else begin m_st = M_RUN; m_cnt = start; end
            end else if (m_st == M_ARMED) begin
                if (trg) begin m_st = M_RUN; m_cnt = start; end
            end else if (m_st == M_RUN) begin
                if (trg)                        m_cnt = start;
                else if (match && mode == 1)    m_st  = M_DONE;
                else if (match && mode == 2)    m_cnt = 0;
                else if (match && mode == 3)    m_cnt = tgt;
                else if (mode <= 2)             m_cnt = (pre + 1) % 1024;
                else if (mode == 3)             m_cnt = pre - 1;
            end
            if (cap) m_capt = pre;
            if (match && bus.cnt_timer_out_i) m_tout = !m_tout;
        end
        m_match = match;
        m_run   = (m_st == M_RUN);
    endtask

    function automatic logic [22:0] dut_vec();
        return {bus.act_cnt_val_o, bus.captured_status_value_o,
                bus.captured_status_tm_running_o, bus.timer_out_o, bus.match_pulse_o};
    endfunction

    function automatic logic [22:0] model_vec();
        return {10'(m_cnt), 10'(m_capt), m_run, m_tout, m_match};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        bus.ctrl0_i = 2'b00; bus.cnt_timer_mode_in_i = 4'd0;
        bus.cnt_timer_trigger_sel_i = 2'b00; bus.cnt_timer_out_i = 1'b0;
        bus.cnt_timer_capt_sel_i = 2'b11; bus.cnt_timer1_target_i = 10'd0;
        bus.cmd_clear_i = 1'b0; bus.cmd_sw_trigger_i = 1'b0;
        bus.ext_trig_i = 2'b00; bus.ext_capt_i = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 23'd0);
        end
    endtask

    task automatic test_periodic_up();
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd2; bus.cnt_timer1_target_i = 10'd5;
        bus.cnt_timer_out_i = 1'b1; bus.ctrl0_i = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL periodic_up cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
            // independent of the model: count is i mod 6, pulse when previous count was 5
            n_checks++;
            if (bus.act_cnt_val_o !== 10'(i % 6) || bus.match_pulse_o !== (i > 0 && i % 6 == 0)) begin
                n_errors++;
                $display("FAIL periodic_seq i=%0d got cnt=%0d match=%b", i, bus.act_cnt_val_o, bus.match_pulse_o);
            end
        end
    endtask

    task automatic test_oneshot_ext();
        int n_match;
        n_match = 0;
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd1; bus.cnt_timer1_target_i = 10'd3;
        bus.cnt_timer_trigger_sel_i = 2'b01; bus.ctrl0_i = 2'b11;
        step(); step();
        bus.ext_trig_i[0] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 1) bus.ext_trig_i[0] = 1'b0;
            if (bus.match_pulse_o) n_match++;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL oneshot_ext cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
            if (i == 2 || i == 3) begin
                n_checks++;
                if (bus.captured_status_tm_running_o !== (i == 3)) begin
                    n_errors++;
                    $display("FAIL oneshot_start_k3 i=%0d got=%b exp=%b", i, bus.captured_status_tm_running_o, (i == 3));
                end
            end
        end
        n_checks++;
        if (bus.act_cnt_val_o !== 10'd3 || bus.captured_status_tm_running_o !== 1'b0 || n_match != 1) begin
            n_errors++;
            $display("FAIL oneshot_done got cnt=%0d run=%b matches=%0d exp cnt=3 run=0 matches=1",
                     bus.act_cnt_val_o, bus.captured_status_tm_running_o, n_match);
        end
    endtask

    task automatic test_down_capture();
        logic [9:0] seq [6];
        seq = '{10'd4, 10'd3, 10'd2, 10'd1, 10'd0, 10'd4};
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd3; bus.cnt_timer1_target_i = 10'd4;
        bus.cnt_timer_capt_sel_i = 2'b01; bus.ctrl0_i = 2'b01;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) bus.ext_capt_i = 1'b1;
            step();
            bus.ext_capt_i = 1'b0;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL down_capture cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
            if (i < 6) begin
                n_checks++;
                if (bus.act_cnt_val_o !== seq[i]) begin
                    n_errors++;
                    $display("FAIL down_seq i=%0d got=%0d exp=%0d", i, bus.act_cnt_val_o, seq[i]);
                end
            end
        end
        n_checks++;
        if (bus.captured_status_value_o !== 10'd2) begin
            n_errors++;
            $display("FAIL down_capt_val got=%0d exp=2", bus.captured_status_value_o);
        end
    endtask

    task automatic test_wrap_clear();
        logic [9:0] wrap [4];
        wrap = '{10'd1021, 10'd1022, 10'd1023, 10'd0};
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd0; bus.cnt_timer1_target_i = 10'd3;
        bus.cnt_timer_capt_sel_i = 2'b00; bus.cnt_timer_out_i = 1'b1;
        bus.ctrl0_i = 2'b01;
        for (int i = 0; i < 1021; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL free_run cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.act_cnt_val_o !== wrap[i]) begin
                n_errors++;
                $display("FAIL wrap i=%0d got=%0d exp=%0d", i, bus.act_cnt_val_o, wrap[i]);
            end
        end
        step(); step(); step();
        // count now equals target: clear, trigger and match all land together
        bus.cmd_clear_i = 1'b1; bus.cmd_sw_trigger_i = 1'b1;
        step();
        bus.cmd_clear_i = 1'b0; bus.cmd_sw_trigger_i = 1'b0;
        n_checks++;
        if (bus.act_cnt_val_o !== 10'd0 || bus.captured_status_value_o !== 10'd0 ||
            bus.match_pulse_o !== 1'b0 || bus.timer_out_o !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_priority got cnt=%0d capt=%0d match=%b tout=%b exp all 0",
                     bus.act_cnt_val_o, bus.captured_status_value_o, bus.match_pulse_o, bus.timer_out_o);
        end
        step();
        n_checks++;
        if (dut_vec() !== model_vec()) begin
            n_errors++;
            $display("FAIL after_clear cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
        end
    endtask

    task automatic test_target_zero();
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd2; bus.cnt_timer1_target_i = 10'd0;
        bus.cnt_timer_out_i = 1'b1; bus.ctrl0_i = 2'b01;
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (bus.act_cnt_val_o !== 10'd0 || bus.match_pulse_o !== 1'b1 || dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL target_zero cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
        end
        bus.ctrl0_i = 2'b00;
        step();
        n_checks++;
        if (bus.captured_status_tm_running_o !== 1'b0 || bus.act_cnt_val_o !== 10'd0 ||
            bus.match_pulse_o !== 1'b0) begin
            n_errors++;
            $display("FAIL disable_idle got run=%b cnt=%0d match=%b exp 0/0/0",
                     bus.captured_status_tm_running_o, bus.act_cnt_val_o, bus.match_pulse_o);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd2; bus.cnt_timer1_target_i = 10'd7;
        bus.cnt_timer_out_i = 1'b1; bus.ctrl0_i = 2'b01;
        repeat (9) step();
        rstn = 1'b0;
        #2;
        n_checks++;
        if (dut_vec() !== 23'd0) begin
            n_errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), 23'd0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (dut_vec() !== model_vec() || (i == 0 && bus.act_cnt_val_o !== 10'd0)) begin
                n_errors++;
                $display("FAIL reset_resume cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        bus.cnt_timer_mode_in_i = 4'd2; bus.cnt_timer1_target_i = 10'd5;
        bus.ctrl0_i = 2'b01;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0)
                bus.ctrl0_i = ($urandom_range(0, 4) == 0) ? 2'b00 : {1'($urandom_range(0, 1)), 1'b1};
            if ($urandom_range(0, 99) == 0)
                bus.cnt_timer_mode_in_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                                     : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                bus.cnt_timer1_target_i = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023))
                                                                     : 10'($urandom_range(0, 12));
            if ($urandom_range(0, 79) == 0) bus.cnt_timer_trigger_sel_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) bus.cnt_timer_capt_sel_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) bus.cnt_timer_out_i = ~bus.cnt_timer_out_i;
            bus.cmd_sw_trigger_i = ($urandom_range(0, 15) == 0);
            bus.cmd_clear_i      = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 4) == 0) bus.ext_trig_i[0] = ~bus.ext_trig_i[0];
            if ($urandom_range(0, 4) == 0) bus.ext_trig_i[1] = ~bus.ext_trig_i[1];
            if ($urandom_range(0, 3) == 0) bus.ext_capt_i = ~bus.ext_capt_i;
            step();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_cyc, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn = 1'b0;
        test_reset();
        test_periodic_up();
        test_oneshot_ext();
        test_down_capture();
        test_wrap_clear();
        test_target_zero();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
